// File: rtl/can_rec_rr_arbiter.sv
// -----------------------------------------------------------------------------
// can_rec_rr_arbiter
//
// Round-robin arbiter between the CAN bus receivers of mopshub_top_32bus and
// the uplink frame builder. A bus with a pending receive interrupt is granted
// by driving its index on can_rec_select and raising rec_req. The builder
// answers with a one-cycle rec_ack once it has sampled the frame. The arbiter
// then pulses irq_clr for the granted bus and moves the round-robin pointer
// past it. A grant that is never acknowledged is aborted after TIMEOUT+1
// cycles.
//
// Ports:
//   clk            system clock (40 MHz domain)
//   rst            asynchronous, active-high reset
//   n_buses        highest enabled bus index; buses above it are masked off
//   irq_can_rec    per-bus level request (bit i = bus i holds an unread frame)
//   rec_ack        one-cycle capture acknowledge from the uplink builder
//   can_rec_select index of the granted bus (holds its value while idle)
//   rec_req        high while a grant is outstanding
//   irq_clr        one-hot, one-cycle clear pulse to the granted receiver
//   timeout_err    one-cycle pulse when a grant is aborted on timeout
//   grant_cnt      number of completed grants, saturating at 16'hFFFF
//
// Every output comes straight from a flip-flop.
// -----------------------------------------------------------------------------
module can_rec_rr_arbiter #(
   parameter int N_BUS   = 32,
   parameter int SEL_W   = 5,
   parameter int TIMEOUT = 1023
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [SEL_W-1:0] n_buses,
   input  logic [N_BUS-1:0] irq_can_rec,
   input  logic             rec_ack,
   output logic [SEL_W-1:0] can_rec_select,
   output logic             rec_req,
   output logic [N_BUS-1:0] irq_clr,
   output logic             timeout_err,
   output logic [15:0]      grant_cnt
);

   localparam int TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      CLR  = 2'd2
   } state_t;

   // Search result of the round-robin scan.
   typedef struct packed {
      logic             found;
      logic [SEL_W-1:0] idx;
   } win_t;

   state_t           state;
   state_t           state_nxt;
   logic [SEL_W-1:0] last_grant;
   logic [SEL_W-1:0] last_grant_nxt;
   logic [SEL_W-1:0] sel_nxt;
   logic             req_nxt;
   logic [N_BUS-1:0] clr_nxt;
   logic             terr_nxt;
   logic [15:0]      cnt_nxt;
   logic [TMO_W-1:0] tmo_cnt;
   logic [TMO_W-1:0] tmo_cnt_nxt;
   logic [N_BUS-1:0] enable_mask;
   logic [N_BUS-1:0] masked_req;
   win_t             win;

   // Round-robin scan: start just after 'last' (or at 0 if 'last' is at or
   // beyond the top enabled bus) and walk at most top+1 positions, wrapping
   // from 'top' back to 0. The first requesting position wins.
   function automatic win_t rr_find(input logic [N_BUS-1:0] req,
                                    input logic [SEL_W-1:0] last,
                                    input logic [SEL_W-1:0] top);
      win_t           res;
      logic [SEL_W:0] start;
      logic [SEL_W:0] cand;
      logic [SEL_W:0] top_ext;
      logic [SEL_W:0] step;
      res     = '0;
      top_ext = {1'b0, top};
      if (last >= top) begin
         start = '0;
      end else begin
         start = {1'b0, last} + {{SEL_W{1'b0}}, 1'b1};
      end
      for (int k = 0; k < N_BUS; k++) begin
         step = (SEL_W + 1)'(k);
         // start <= top and step <= top, so one subtraction wraps fully.
         cand = start + step;
         if (cand > top_ext) begin
            cand = cand - top_ext - {{SEL_W{1'b0}}, 1'b1};
         end else begin
            cand = cand;
         end
         if (!res.found && (step <= top_ext) && req[cand[SEL_W-1:0]]) begin
            res.found = 1'b1;
            res.idx   = cand[SEL_W-1:0];
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

   // Enable mask: bus i takes part only when i <= n_buses.
   always_comb begin
      enable_mask = '0;
      for (int i = 0; i < N_BUS; i++) begin
         enable_mask[i] = (SEL_W'(i) <= n_buses);
      end
   end

   assign masked_req = irq_can_rec & enable_mask;
   assign win        = rr_find(masked_req, last_grant, n_buses);

   // Next-state and next-output logic; every target defaults to "hold" or
   // "inactive" so single-cycle pulses drop on their own.
   always_comb begin
      state_nxt      = state;
      last_grant_nxt = last_grant;
      sel_nxt        = can_rec_select;
      req_nxt        = rec_req;
      clr_nxt        = '0;
      terr_nxt       = 1'b0;
      cnt_nxt        = grant_cnt;
      tmo_cnt_nxt    = tmo_cnt;
      case (state)
         IDLE: begin
            if (win.found) begin
               sel_nxt     = win.idx;
               req_nxt     = 1'b1;
               tmo_cnt_nxt = '0;
               state_nxt   = REQ;
            end else begin
               state_nxt = IDLE;
            end
         end
         REQ: begin
            // Priority: ack beats withdrawal beats timeout.
            if (rec_ack) begin
               req_nxt                 = 1'b0;
               clr_nxt[can_rec_select] = 1'b1;
               last_grant_nxt          = can_rec_select;
               if (grant_cnt != 16'hFFFF) begin
                  cnt_nxt = grant_cnt + 16'd1;
               end else begin
                  cnt_nxt = grant_cnt;
               end
               state_nxt = CLR;
            end else if (!irq_can_rec[can_rec_select]) begin
               // Receiver dropped its request: abandon quietly, keep pointer.
               req_nxt   = 1'b0;
               state_nxt = IDLE;
            end else if (tmo_cnt == TMO_LAST) begin
               // Stuck bus: give up and move the pointer past it.
               req_nxt        = 1'b0;
               terr_nxt       = 1'b1;
               last_grant_nxt = can_rec_select;
               state_nxt      = IDLE;
            end else begin
               tmo_cnt_nxt = tmo_cnt + {{(TMO_W-1){1'b0}}, 1'b1};
            end
         end
         CLR: begin
            // One dead cycle so a request bit that falls right after the
            // clear pulse is not re-granted.
            state_nxt = IDLE;
         end
         default: begin
            req_nxt   = 1'b0;
            state_nxt = IDLE;
         end
      endcase
   end

   // State, pointer, timeout counter and all registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         last_grant     <= SEL_W'(N_BUS - 1);
         can_rec_select <= '0;
         rec_req        <= 1'b0;
         irq_clr        <= '0;
         timeout_err    <= 1'b0;
         grant_cnt      <= 16'd0;
         tmo_cnt        <= '0;
      end else begin
         state          <= state_nxt;
         last_grant     <= last_grant_nxt;
         can_rec_select <= sel_nxt;
         rec_req        <= req_nxt;
         irq_clr        <= clr_nxt;
         timeout_err    <= terr_nxt;
         grant_cnt      <= cnt_nxt;
         tmo_cnt        <= tmo_cnt_nxt;
      end
   end

endmodule

// File: tb/tb_can_rec_rr_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for can_rec_rr_arbiter. Stimulus pushes the expected event stream
// (grant, clear, timeout) into a queue. A monitor watches the DUT outputs on
// the falling clock edge and checks each observed event against the queue.
// -----------------------------------------------------------------------------
module tb_can_rec_rr_arbiter;

   localparam int K_GRANT = 0;
   localparam int K_CLR   = 1;
   localparam int K_TMO   = 2;

   typedef struct {
      int          kind;
      int          sel;
      logic [15:0] cnt;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [4:0]  n_buses;
   logic [31:0] irq_can_rec;
   logic        rec_ack;
   logic [4:0]  can_rec_select;
   logic        rec_req;
   logic [31:0] irq_clr;
   logic        timeout_err;
   logic [15:0] grant_cnt;

   exp_t q[$];
   int   tests;
   int   fails;

   can_rec_rr_arbiter dut (
      .clk            (clk),
      .rst            (rst),
      .n_buses        (n_buses),
      .irq_can_rec    (irq_can_rec),
      .rec_ack        (rec_ack),
      .can_rec_select (can_rec_select),
      .rec_req        (rec_req),
      .irq_clr        (irq_clr),
      .timeout_err    (timeout_err),
      .grant_cnt      (grant_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input int kind, input int sel, input logic [15:0] cnt);
      exp_t e;
      e.kind = kind;
      e.sel  = sel;
      e.cnt  = cnt;
      q.push_back(e);
   endtask

   task automatic check_event(input int kind);
      exp_t e;
      if (q.size() == 0) begin
         tests++;
         fails++;
         $display("FAIL unexpected_event: got kind %0d sel %0d expected none", kind, can_rec_select);
      end else begin
         e = q.pop_front();
         check("event_kind", kind, e.kind);
         check("event_sel", {27'd0, can_rec_select}, e.sel);
         if (kind == K_CLR) begin
            check("irq_clr_onehot", irq_clr, 32'd1 << e.sel);
            check("grant_cnt", {16'd0, grant_cnt}, {16'd0, e.cnt});
            check("req_low_in_clr", {31'd0, rec_req}, 32'd0);
         end else if (kind == K_TMO) begin
            check("tmo_no_clr", irq_clr, 32'd0);
            check("req_low_on_tmo", {31'd0, rec_req}, 32'd0);
         end
      end
   endtask

   // Monitor: grant = rising rec_req, clear = any irq_clr bit, timeout pulse.
   initial begin
      logic prev_req;
      prev_req = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (rec_req && !prev_req) check_event(K_GRANT);
            if (irq_clr != 32'd0)     check_event(K_CLR);
            if (timeout_err)          check_event(K_TMO);
         end
         prev_req = rec_req;
      end
   end

   task automatic wait_req();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (rec_req) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         tests++;
         fails++;
         $display("FAIL wait_req: got no rec_req within 64 cycles, expected rec_req");
      end
   endtask

   task automatic ack_after(input int n);
      repeat (n) @(negedge clk);
      rec_ack = 1'b1;
      @(negedge clk);
      rec_ack = 1'b0;
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int hi;
      tests       = 0;
      fails       = 0;
      rst         = 1'b1;
      n_buses     = 5'd31;
      irq_can_rec = 32'd0;
      rec_ack     = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_select", {27'd0, can_rec_select}, 32'd0);
      check("rst_req", {31'd0, rec_req}, 32'd0);
      check("rst_clr", irq_clr, 32'd0);
      check("rst_terr", {31'd0, timeout_err}, 32'd0);
      check("rst_cnt", {16'd0, grant_cnt}, 32'd0);
      rst = 1'b0;

      // Rotation over all 32 buses, then wrap back to 0.
      irq_can_rec = 32'hFFFF_FFFF;
      for (int i = 0; i < 33; i++) begin
         push(K_GRANT, i % 32, 16'd0);
         push(K_CLR, i % 32, 16'(i + 1));
         wait_req();
         ack_after(2);
      end
      irq_can_rec = 32'd0;
      repeat (3) @(negedge clk);

      // Asynchronous reset in the middle of a grant to bus 0.
      irq_can_rec = 32'h1;
      push(K_GRANT, 0, 16'd0);
      wait_req();
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("midrst_req", {31'd0, rec_req}, 32'd0);
      check("midrst_select", {27'd0, can_rec_select}, 32'd0);
      check("midrst_clr", irq_clr, 32'd0);
      check("midrst_cnt", {16'd0, grant_cnt}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      push(K_GRANT, 0, 16'd0);
      push(K_CLR, 0, 16'd1);
      wait_req();
      ack_after(1);
      irq_can_rec = 32'd0;
      repeat (2) @(negedge clk);

      // Masking with n_buses=3: bus 31 never wins; pointer is at 0 here.
      n_buses     = 5'd3;
      irq_can_rec = 32'h8000_0009;
      for (int i = 0; i < 4; i++) begin
         push(K_GRANT, (i % 2 == 0) ? 3 : 0, 16'd0);
         push(K_CLR, (i % 2 == 0) ? 3 : 0, 16'(i + 2));
         wait_req();
         ack_after(1);
      end
      irq_can_rec = 32'd0;
      n_buses     = 5'd31;
      repeat (2) @(negedge clk);

      // Timeout on bus 2; as sole requester it is re-granted afterwards.
      irq_can_rec = 32'h4;
      push(K_GRANT, 2, 16'd0);
      push(K_TMO, 2, 16'd0);
      push(K_GRANT, 2, 16'd0);
      push(K_CLR, 2, 16'd6);
      wait_req();
      hi = 1;
      for (int i = 0; i < 1100; i++) begin
         @(negedge clk);
         if (rec_req) hi++;
         else break;
      end
      check("tmo_req_cycles", hi, 32'd1024);
      check("tmo_pulse", {31'd0, timeout_err}, 32'd1);
      wait_req();
      ack_after(1);
      irq_can_rec = 32'd0;
      repeat (2) @(negedge clk);

      // Withdrawal of bus 5 before ack, then a late ack that must be ignored.
      irq_can_rec = 32'h20;
      push(K_GRANT, 5, 16'd0);
      wait_req();
      repeat (2) @(negedge clk);
      irq_can_rec = 32'd0;
      @(negedge clk);
      check("wd_req_low", {31'd0, rec_req}, 32'd0);
      check("wd_cnt", {16'd0, grant_cnt}, 32'd6);
      rec_ack = 1'b1;
      @(negedge clk);
      rec_ack = 1'b0;
      repeat (3) @(negedge clk);
      check("late_ack_cnt", {16'd0, grant_cnt}, 32'd6);

      // Ack in the same cycle as withdrawal: the ack wins.
      irq_can_rec = 32'h20;
      push(K_GRANT, 5, 16'd0);
      push(K_CLR, 5, 16'd7);
      wait_req();
      @(negedge clk);
      irq_can_rec = 32'd0;
      rec_ack     = 1'b1;
      @(negedge clk);
      rec_ack = 1'b0;
      repeat (2) @(negedge clk);

      // Ack on the exact timeout-expiry edge: clear, no timeout error.
      irq_can_rec = 32'h4;
      push(K_GRANT, 2, 16'd0);
      push(K_CLR, 2, 16'd8);
      wait_req();
      repeat (1023) @(negedge clk);
      rec_ack = 1'b1;
      @(negedge clk);
      rec_ack = 1'b0;
      check("coll_terr", {31'd0, timeout_err}, 32'd0);
      irq_can_rec = 32'd0;
      repeat (2) @(negedge clk);

      // Saturation: preload the counter just below the top.
      force dut.grant_cnt = 16'hFFFE;
      @(negedge clk);
      release dut.grant_cnt;
      irq_can_rec = 32'h1;
      for (int i = 0; i < 2; i++) begin
         push(K_GRANT, 0, 16'd0);
         push(K_CLR, 0, 16'hFFFF);
         wait_req();
         ack_after(1);
      end
      irq_can_rec = 32'd0;
      repeat (5) @(negedge clk);
      check("queue_drained", q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
